print_sequencer: RTL

Sequences ASCII rendering of a 32-bit value onto a byte-wide character stream, one character per handshake. It takes a print request (value, radix, digit count, optional line terminator), latches it, and emits digits most-significant first over a valid/ready interface. Digits are uppercase hex or binary, using the same order as the combinational printers. It sits between status/debug logic and the UART transmit path, so combinational printer vectors never have to be parallel-loaded into the transmitter.

---
 rtl/print_sequencer.sv | 84 ++++++++
 1 files changed

// File: rtl/print_sequencer.sv
// print_sequencer: streams a latched 32-bit value as uppercase hex or binary ASCII, MSD first, with optional CR/LF.
module print_sequencer #(
  parameter int MAX_HEX = 8,
  parameter int MAX_BIN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        fmt,
  input  logic [5:0]  num_chars,
  input  logic [31:0] number_in,
  input  logic        add_newline,
  input  logic        char_ready,
  output logic [7:0]  char_out,
  output logic        char_valid,
  output logic        busy,
  output logic        done
);
  localparam logic [2:0] IDLE = 3'd0, DIGIT = 3'd1, CR = 3'd2, LF = 3'd3, FIN = 3'd4;
  localparam logic [5:0] HMAX = 6'(MAX_HEX), BMAX = 6'(MAX_BIN);
  logic [2:0] state, nxt;
  logic [31:0] num, num_n;
  logic fmt_r, fmt_n, nl, nl_n, acc, xfer, act;
  logic [4:0] idx, idx_n;
  logic [5:0] n;
  logic [3:0] nib;
  logic [7:0] ch;
  always_comb begin
    n = fmt ? (num_chars > BMAX ? BMAX : num_chars) : (num_chars > HMAX ? HMAX : num_chars);
    acc = start && !busy;
    xfer = char_valid && char_ready;
    nxt = state;
    num_n = num;
    fmt_n = fmt_r;
    nl_n = nl;
    idx_n = idx;
    if (acc) begin
      num_n = number_in;
      fmt_n = fmt;
      nl_n = add_newline;
      idx_n = 5'(n - 6'd1);
      nxt = n != 6'd0 ? DIGIT : add_newline ? CR : FIN;
    end else if (state == FIN) begin
      nxt = IDLE;
    end else if (xfer) begin
      if (state == DIGIT) begin
        idx_n = idx - 5'd1;
        if (idx == 5'd0) nxt = nl ? CR : FIN;
      end else begin
        nxt = state == CR ? LF : FIN;
      end
    end
  end
  // Outputs are registered from next-state values so the first character appears the cycle after acceptance.
  always_comb begin
    nib = 4'(num_n >> {idx_n[2:0], 2'b00});
    act = nxt == DIGIT || nxt == CR || nxt == LF;
    ch = nxt == CR ? 8'h0D : nxt == LF ? 8'h0A : nxt != DIGIT ? 8'h00 :
         fmt_n ? {7'h18, num_n[idx_n]} : nib < 4'd10 ? {4'h3, nib} : 8'h37 + {4'h0, nib};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      num <= '0;
      fmt_r <= 1'b0;
      nl <= 1'b0;
      idx <= '0;
      char_out <= 8'h00;
      char_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      num <= num_n;
      fmt_r <= fmt_n;
      nl <= nl_n;
      idx <= idx_n;
      char_out <= ch;
      char_valid <= act;
      busy <= act;
      done <= nxt == FIN;
    end
  end
endmodule
